// File: rtl/beehive_vr_pkg.sv
// Shared VR engine types: beehive/Prepare/Commit headers,
// header offsets and the message parser state encoding.
package beehive_vr_pkg;

    localparam int DATA_W     = 512;
    localparam int LOG_W      = DATA_W;
    localparam int DATA_BYTES = DATA_W / 8;
    localparam int PADBYTES_W = $clog2(DATA_BYTES);

    localparam logic [7:0] VR_PREPARE = 8'd4;
    localparam logic [7:0] VR_COMMIT  = 8'd6;

    typedef struct packed {
        logic [7:0]  msg_type;
        logic [31:0] client_id;
        logic [31:0] req_id;
        logic [31:0] msg_len;
    } beehive_hdr;

    typedef struct packed {
        logic [63:0] view;
        logic [63:0] op_num;
        logic [63:0] batch_start;
        logic [63:0] commit_num;
    } prepare_msg_hdr;

    typedef struct packed {
        logic [63:0] view;
        logic [63:0] commit_num;
    } commit_msg_hdr;

    localparam int BEEHIVE_HDR_W     = $bits(beehive_hdr);
    localparam int PREPARE_MSG_HDR_W = $bits(prepare_msg_hdr);
    localparam int COMMIT_MSG_HDR_W  = $bits(commit_msg_hdr);

    localparam int BEEHIVE_HDR_BYTES       = BEEHIVE_HDR_W / 8;
    localparam int PREPARE_TOTAL_HDR_BYTES = BEEHIVE_HDR_BYTES + PREPARE_MSG_HDR_W / 8;
    localparam int COMMIT_TOTAL_HDR_BYTES  = BEEHIVE_HDR_BYTES + COMMIT_MSG_HDR_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        HDR_OUT,
        PAYLOAD,
        DRAIN
    } parser_state;

    function automatic logic [PADBYTES_W-1:0] hdr_offset(input logic [7:0] msg_type);
        if (msg_type == VR_PREPARE)
            return PADBYTES_W'(PREPARE_TOTAL_HDR_BYTES);
        else if (msg_type == VR_COMMIT)
            return PADBYTES_W'(COMMIT_TOTAL_HDR_BYTES);
        else
            return PADBYTES_W'(BEEHIVE_HDR_BYTES);
    endfunction

endpackage

// File: rtl/beehive_vr_realign.sv
// Carry register plus byte shifter: stitches the tail of the previous
// line (from a runtime byte offset) onto the head of the current one.
module beehive_vr_realign
    import beehive_vr_pkg::*;
#(
    parameter int W  = DATA_W,
    parameter int OW = PADBYTES_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          load,
    input  logic [OW-1:0] start_offset,
    input  logic [W-1:0]  line,
    output logic [OW-1:0] offset,
    output logic [W-1:0]  carry,
    output logic [W-1:0]  merged
);

    localparam int SW = $clog2(W) + 1;

    logic [SW-1:0] sh_start;
    logic [SW-1:0] sh_cur;

    assign sh_start = SW'({start_offset, 3'b000});
    assign sh_cur   = SW'({offset, 3'b000});

    // carry bytes land at byte 0, current line's head fills the rest
    assign merged = carry | (line >> (SW'(W) - sh_cur));

    // capture the offset at message start, then keep the line tail
    always_ff @(posedge clk) begin
        if (rst) begin
            offset <= '0;
            carry  <= '0;
        end else if (start) begin
            offset <= start_offset;
            carry  <= line << sh_start;
        end else if (load) begin
            carry  <= line << sh_cur;
        end
    end

endmodule

// File: rtl/beehive_vr_msg_parser.sv
// VR message parser: splits headers off line 0 and realigns payload.
// Optional counters: define BEEHIVE_VR_PARSER_STATS_EN.
module beehive_vr_msg_parser
    import beehive_vr_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
`ifdef BEEHIVE_VR_PARSER_STATS_EN
    output logic [31:0]                  parser_stat_prepare_cnt,
    output logic [31:0]                  parser_stat_commit_cnt,
    output logic [31:0]                  parser_stat_other_cnt,
    output logic [31:0]                  parser_stat_err_cnt,
`endif
    input  logic                         src_parser_data_val,
    input  logic [DATA_W-1:0]            src_parser_data,
    input  logic                         src_parser_data_last,
    input  logic [PADBYTES_W-1:0]        src_parser_data_padbytes,
    output logic                         parser_src_data_rdy,
    output logic                         parser_dst_hdr_val,
    output logic [BEEHIVE_HDR_W-1:0]     parser_dst_beehive_hdr,
    output logic [PREPARE_MSG_HDR_W-1:0] parser_dst_prepare_hdr,
    output logic [COMMIT_MSG_HDR_W-1:0]  parser_dst_commit_hdr,
    output logic                         parser_dst_hdr_err,
    input  logic                         dst_parser_hdr_rdy,
    output logic                         parser_dst_data_val,
    output logic [DATA_W-1:0]            parser_dst_data,
    output logic                         parser_dst_data_last,
    output logic [PADBYTES_W-1:0]        parser_dst_data_padbytes,
    input  logic                         dst_parser_data_rdy
);

    localparam int PW1 = PADBYTES_W + 1;

    parser_state             state;
    logic                    last0_q;
    logic                    nopay_q;
    logic [PADBYTES_W-1:0]   drain_pad_q;
    logic [PADBYTES_W-1:0]   off_q;
    logic [PADBYTES_W-1:0]   in_off;
    logic [7:0]              in_type;
    logic [PW1-1:0]          in_valid;
    logic [PW1-1:0]          tail_pad;
    logic                    src_fire;
    logic                    hdr_fire;
    logic                    cur_short;
    logic [DATA_W-1:0]       carry;
    logic [DATA_W-1:0]       merged;

    assign in_type  = src_parser_data[DATA_W-1 -: 8];
    assign in_off   = hdr_offset(in_type);
    assign in_valid = PW1'(DATA_BYTES) - {1'b0, src_parser_data_padbytes};
    // the carry fills the front of the last line, so its pad shrinks
    assign tail_pad = {1'b0, src_parser_data_padbytes} + {1'b0, off_q}
                    - PW1'(DATA_BYTES);
    assign cur_short = in_valid <= {1'b0, off_q};

    assign parser_src_data_rdy = !rst &&
        ((state == IDLE) || ((state == PAYLOAD) && dst_parser_data_rdy));
    assign src_fire = src_parser_data_val && parser_src_data_rdy;
    assign hdr_fire = parser_dst_hdr_val && dst_parser_hdr_rdy;

    beehive_vr_realign u_realign (
        .clk          (clk),
        .rst          (rst),
        .start        ((state == IDLE) && src_fire),
        .load         ((state == PAYLOAD) && src_fire),
        .start_offset (in_off),
        .line         (src_parser_data),
        .offset       (off_q),
        .carry        (carry),
        .merged       (merged)
    );

    // payload channel follows the input line, or the carry when draining
    always_comb begin
        parser_dst_data_val      = 1'b0;
        parser_dst_data          = merged;
        parser_dst_data_last     = 1'b0;
        parser_dst_data_padbytes = '0;
        if (state == PAYLOAD) begin
            parser_dst_data_val = src_parser_data_val;
            if (src_parser_data_last && cur_short) begin
                parser_dst_data_last     = 1'b1;
                parser_dst_data_padbytes = tail_pad[PADBYTES_W-1:0];
            end
        end else if (state == DRAIN) begin
            parser_dst_data_val      = 1'b1;
            parser_dst_data          = carry;
            parser_dst_data_last     = 1'b1;
            parser_dst_data_padbytes = drain_pad_q;
        end
    end

    // message FSM with registered header channel
    always_ff @(posedge clk) begin
        if (rst) begin
            state                  <= IDLE;
            parser_dst_hdr_val     <= 1'b0;
            parser_dst_beehive_hdr <= '0;
            parser_dst_prepare_hdr <= '0;
            parser_dst_commit_hdr  <= '0;
            parser_dst_hdr_err     <= 1'b0;
            last0_q                <= 1'b0;
            nopay_q                <= 1'b0;
            drain_pad_q            <= '0;
        end else begin
            unique case (state)
                IDLE: if (src_fire) begin
                    parser_dst_hdr_val     <= 1'b1;
                    parser_dst_beehive_hdr <= src_parser_data[DATA_W-1 -: BEEHIVE_HDR_W];
                    parser_dst_prepare_hdr <= (in_type == VR_PREPARE) ?
                        src_parser_data[DATA_W-1-BEEHIVE_HDR_W -: PREPARE_MSG_HDR_W] : '0;
                    parser_dst_commit_hdr  <= (in_type == VR_COMMIT) ?
                        src_parser_data[DATA_W-1-BEEHIVE_HDR_W -: COMMIT_MSG_HDR_W] : '0;
                    parser_dst_hdr_err     <= src_parser_data_last &&
                                              (in_valid < {1'b0, in_off});
                    last0_q                <= src_parser_data_last;
                    nopay_q                <= in_valid <= {1'b0, in_off};
                    drain_pad_q            <= PADBYTES_W'({1'b0, src_parser_data_padbytes}
                                                        + {1'b0, in_off});
                    state                  <= HDR_OUT;
                end
                HDR_OUT: if (dst_parser_hdr_rdy) begin
                    parser_dst_hdr_val <= 1'b0;
                    if (last0_q)
                        state <= nopay_q ? IDLE : DRAIN;
                    else
                        state <= PAYLOAD;
                end
                PAYLOAD: if (src_fire && src_parser_data_last) begin
                    if (cur_short) begin
                        state <= IDLE;
                    end else begin
                        drain_pad_q <= PADBYTES_W'({1'b0, src_parser_data_padbytes}
                                                  + {1'b0, off_q});
                        state       <= DRAIN;
                    end
                end
                DRAIN: if (dst_parser_data_rdy) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BEEHIVE_VR_PARSER_STATS_EN
    logic [7:0] hdr_type;
    assign hdr_type = parser_dst_beehive_hdr[BEEHIVE_HDR_W-1 -: 8];

    // per-type and error counters, bumped on each header handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            parser_stat_prepare_cnt <= '0;
            parser_stat_commit_cnt  <= '0;
            parser_stat_other_cnt   <= '0;
            parser_stat_err_cnt     <= '0;
        end else if (hdr_fire) begin
            if (hdr_type == VR_PREPARE)
                parser_stat_prepare_cnt <= parser_stat_prepare_cnt + 32'd1;
            else if (hdr_type == VR_COMMIT)
                parser_stat_commit_cnt  <= parser_stat_commit_cnt + 32'd1;
            else
                parser_stat_other_cnt   <= parser_stat_other_cnt + 32'd1;
            if (parser_dst_hdr_err)
                parser_stat_err_cnt     <= parser_stat_err_cnt + 32'd1;
        end
    end
`else
    logic unused_hdr_fire;
    assign unused_hdr_fire = hdr_fire;
`endif

endmodule

// File: tb/tb_beehive_vr_msg_parser.sv
// Randomised bench for beehive_vr_msg_parser against a byte-level
// message model with stalls on all three channels.
module tb_beehive_vr_msg_parser;
    import beehive_vr_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                         rst;
    logic                         src_val;
    logic [DATA_W-1:0]            src_data;
    logic                         src_last;
    logic [PADBYTES_W-1:0]        src_pad;
    logic                         src_rdy;
    logic                         hdr_val;
    logic [BEEHIVE_HDR_W-1:0]     bh_hdr;
    logic [PREPARE_MSG_HDR_W-1:0] pr_hdr;
    logic [COMMIT_MSG_HDR_W-1:0]  cm_hdr;
    logic                         hdr_err;
    logic                         hdr_rdy;
    logic                         data_val;
    logic [DATA_W-1:0]            data;
    logic                         data_last;
    logic [PADBYTES_W-1:0]        data_pad;
    logic                         data_rdy;
`ifdef BEEHIVE_VR_PARSER_STATS_EN
    logic [31:0] st_pr, st_cm, st_ot, st_er;
`endif

    beehive_vr_msg_parser dut (
        .clk                      (clk),
        .rst                      (rst),
`ifdef BEEHIVE_VR_PARSER_STATS_EN
        .parser_stat_prepare_cnt  (st_pr),
        .parser_stat_commit_cnt   (st_cm),
        .parser_stat_other_cnt    (st_ot),
        .parser_stat_err_cnt      (st_er),
`endif
        .src_parser_data_val      (src_val),
        .src_parser_data          (src_data),
        .src_parser_data_last     (src_last),
        .src_parser_data_padbytes (src_pad),
        .parser_src_data_rdy      (src_rdy),
        .parser_dst_hdr_val       (hdr_val),
        .parser_dst_beehive_hdr   (bh_hdr),
        .parser_dst_prepare_hdr   (pr_hdr),
        .parser_dst_commit_hdr    (cm_hdr),
        .parser_dst_hdr_err       (hdr_err),
        .dst_parser_hdr_rdy       (hdr_rdy),
        .parser_dst_data_val      (data_val),
        .parser_dst_data          (data),
        .parser_dst_data_last     (data_last),
        .parser_dst_data_padbytes (data_pad),
        .dst_parser_data_rdy      (data_rdy)
    );

    typedef struct {
        logic [DATA_W-1:0]     d;
        logic                  last;
        logic [PADBYTES_W-1:0] pad;
    } line_t;

    typedef struct {
        logic [7:0]                   typ;
        logic [BEEHIVE_HDR_W-1:0]     bh;
        logic [PREPARE_MSG_HDR_W-1:0] pr;
        logic [COMMIT_MSG_HDR_W-1:0]  cm;
        logic                         err;
    } hdr_t;

    line_t src_q[$];
    line_t exp_d_q[$];
    hdr_t  exp_h_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int stall    = 0;
    bit hold     = 1'b0;
    int data_seen = 0;
    int cnt_pr = 0, cnt_cm = 0, cnt_ot = 0, cnt_er = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // byte-level model: build the frame, the headers and the payload lines
    task automatic add_msg(input logic [7:0] typ, input int len);
        byte unsigned m [0:1023];
        int nl, off, plen, pl, idx;
        line_t ln;
        hdr_t  h;
        nl = (len + DATA_BYTES - 1) / DATA_BYTES;
        for (int i = 0; i < nl * DATA_BYTES; i++) m[i] = 8'($urandom);
        m[0] = typ;
        for (int i = 0; i < nl; i++) begin
            ln.d = '0;
            for (int k = 0; k < DATA_BYTES; k++)
                ln.d[DATA_W-1-8*k -: 8] = m[i*DATA_BYTES+k];
            ln.last = (i == nl - 1);
            ln.pad  = ln.last ? PADBYTES_W'(nl * DATA_BYTES - len) : '0;
            src_q.push_back(ln);
        end
        off = (typ == 8'd4) ? 45 : (typ == 8'd6) ? 29 : 13;
        h.typ = typ;
        h.bh = '0;
        h.pr = '0;
        h.cm = '0;
        for (int k = 0; k < 13; k++) h.bh = {h.bh[BEEHIVE_HDR_W-9:0], m[k]};
        if (typ == 8'd4)
            for (int k = 13; k < 45; k++) h.pr = {h.pr[PREPARE_MSG_HDR_W-9:0], m[k]};
        if (typ == 8'd6)
            for (int k = 13; k < 29; k++) h.cm = {h.cm[COMMIT_MSG_HDR_W-9:0], m[k]};
        h.err = (len < off);
        exp_h_q.push_back(h);
        plen = len - off;
        if (plen > 0) begin
            pl = (plen + DATA_BYTES - 1) / DATA_BYTES;
            for (int j = 0; j < pl; j++) begin
                ln.d = '0;
                for (int k = 0; k < DATA_BYTES; k++) begin
                    idx = off + j * DATA_BYTES + k;
                    ln.d[DATA_W-1-8*k -: 8] = (idx < len) ? m[idx] : 8'h00;
                end
                ln.last = (j == pl - 1);
                ln.pad  = ln.last ? PADBYTES_W'(pl * DATA_BYTES - plen) : '0;
                exp_d_q.push_back(ln);
            end
        end
    endtask

    task automatic step();
        line_t e;
        hdr_t  h;
        int    v;
        logic [DATA_W-1:0] g;
        logic [DATA_W-1:0] x;
        @(negedge clk);
        if (!hold) begin
            if (src_q.size() > 0 && $urandom_range(99) >= stall) begin
                src_val  = 1'b1;
                src_data = src_q[0].d;
                src_last = src_q[0].last;
                src_pad  = src_q[0].pad;
            end else begin
                src_val  = 1'b0;
                src_last = 1'b0;
            end
        end
        hdr_rdy  = ($urandom_range(99) >= stall);
        data_rdy = ($urandom_range(99) >= stall);
        #1;
        if (hdr_val) check("payload_before_hdr", data_val, 1'b0);
        hold = src_val && !src_rdy;
        if (src_val && src_rdy) src_q.delete(0);
        if (hdr_val && hdr_rdy) begin
            if (exp_h_q.size() == 0) begin
                check("hdr_extra", hdr_val, 1'b0);
            end else begin
                h = exp_h_q[0];
                exp_h_q.delete(0);
                check("beehive_hdr", bh_hdr, h.bh);
                check("prepare_hdr", pr_hdr, h.pr);
                check("commit_hdr", cm_hdr, h.cm);
                check("hdr_err", hdr_err, h.err);
                if (h.typ == 8'd4) cnt_pr++;
                else if (h.typ == 8'd6) cnt_cm++;
                else cnt_ot++;
                if (h.err) cnt_er++;
            end
        end
        if (data_val && data_rdy) begin
            data_seen++;
            if (exp_d_q.size() == 0) begin
                check("data_extra", data_val, 1'b0);
            end else begin
                e = exp_d_q[0];
                exp_d_q.delete(0);
                v = e.last ? DATA_BYTES - int'(e.pad) : DATA_BYTES;
                g = data;
                x = e.d;
                for (int k = 0; k < DATA_BYTES; k++)
                    if (k >= v) begin
                        g[DATA_W-1-8*k -: 8] = 8'h00;
                        x[DATA_W-1-8*k -: 8] = 8'h00;
                    end
                check("data", g, x);
                check("data_last", data_last, e.last);
                if (e.last) check("data_pad", data_pad, e.pad);
            end
        end
    endtask

    task automatic run_all(input int bound);
        int c;
        c = 0;
        while ((src_q.size() > 0 || exp_h_q.size() > 0 ||
                exp_d_q.size() > 0 || hold) && c < bound) begin
            step();
            c++;
        end
        check("queues_drained", src_q.size() + exp_h_q.size() + exp_d_q.size(), 0);
        for (int i = 0; i < 4; i++) step();
    endtask

`ifdef BEEHIVE_VR_PARSER_STATS_EN
    task automatic check_stats();
        check("stat_prepare", st_pr, cnt_pr);
        check("stat_commit", st_cm, cnt_cm);
        check("stat_other", st_ot, cnt_ot);
        check("stat_err", st_er, cnt_er);
    endtask
`endif

    initial begin
        int r, len, c;
        logic [7:0] typ;
        rst      = 1'b1;
        src_val  = 1'b0;
        src_data = '0;
        src_last = 1'b0;
        src_pad  = '0;
        hdr_rdy  = 1'b0;
        data_rdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_src_rdy", src_rdy, 1'b0);
        check("rst_hdr_val", hdr_val, 1'b0);
        check("rst_data_val", data_val, 1'b0);
        check("rst_beehive_hdr", bh_hdr, '0);
        rst = 1'b0;

        stall = 0;
        add_msg(8'd4, 145);
        add_msg(8'd6, 29);
        add_msg(8'd9, 77);
        add_msg(8'd4, 34);
        add_msg(8'd6, 100);
        run_all(2000);

        stall = 35;
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(3);
            if (r == 0) typ = 8'd4;
            else if (r == 1) typ = 8'd6;
            else begin
                typ = 8'($urandom_range(255));
                if (typ == 8'd4 || typ == 8'd6) typ = 8'd9;
            end
            len = ($urandom_range(4) == 0) ? $urandom_range(50, 1) : $urandom_range(300, 1);
            add_msg(typ, len);
        end
        run_all(60000);
`ifdef BEEHIVE_VR_PARSER_STATS_EN
        check_stats();
`endif

        stall = 0;
        data_seen = 0;
        add_msg(8'd4, 300);
        c = 0;
        while (data_seen == 0 && c < 100) begin
            step();
            c++;
        end
        check("payload_reached", data_seen > 0, 1'b1);
        @(negedge clk);
        rst      = 1'b1;
        src_val  = 1'b0;
        src_last = 1'b0;
        hdr_rdy  = 1'b0;
        data_rdy = 1'b0;
        hold     = 1'b0;
        #1;
        check("rst_mid_src_rdy", src_rdy, 1'b0);
        @(negedge clk);
        #1;
        check("rst_mid_hdr_val", hdr_val, 1'b0);
        check("rst_mid_data_val", data_val, 1'b0);
        src_q.delete();
        exp_h_q.delete();
        exp_d_q.delete();
        cnt_pr = 0;
        cnt_cm = 0;
        cnt_ot = 0;
        cnt_er = 0;
`ifdef BEEHIVE_VR_PARSER_STATS_EN
        check_stats();
`endif
        @(negedge clk);
        rst = 1'b0;
        stall = 20;
        add_msg(8'd6, 100);
        run_all(2000);
`ifdef BEEHIVE_VR_PARSER_STATS_EN
        check_stats();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
